// File: rtl/timestamp_inserter_if.sv
// AXI-stream bundle for the timestamp inserter datapath.
//   tvalid/tready : handshake
//   tdata         : DATA_W payload bits
//   tkeep         : one bit per tdata byte (tkeep[n] covers tdata[8n+7:8n])
//   tlast         : last beat of a packet
//   tuser         : USER_W sideband, carried through untouched
// master drives the payload and samples tready; slave is the opposite side.
interface timestamp_inserter_if #(
   parameter int DATA_W = 512,
   parameter int USER_W = 16
) ();
   logic                  tvalid;
   logic                  tready;
   logic [DATA_W-1:0]     tdata;
   logic [DATA_W/8-1:0]   tkeep;
   logic                  tlast;
   logic [USER_W-1:0]     tuser;

   modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/timestamp_inserter.sv
// Inline AXI-stream register slice that stamps {nb_sync, curr_tick} into the
// first free timestamp slot (after the Ethernet/VLAN header) of the first beat
// of packets flagged by i_mark.
//
// Ports:
//   aclk, aresetn   : clock, asynchronous active-low reset
//   s_axis          : upstream stream (slave modport)
//   m_axis          : downstream stream (master modport), one register stage
//   i_enable        : global inject enable
//   i_mark          : mark current packet; only looked at on a first-beat handshake
//   i_sync_pulse    : increments o_nb_sync
//   o_nb_sync       : 32-bit sync counter
//   o_curr_tick     : 64-bit free-running tick counter
//   o_injected      : a stamp was loaded into the output register
//   o_no_slot       : marked first beat loaded without a free slot
//
// Build option TIMESTAMP_INSERTER_STATS_EN adds o_inject_cnt / o_noslot_cnt,
// 32-bit saturating event counters.
module timestamp_inserter #(
   parameter int          DATA_W       = 512,
   parameter int          HDR_BYTES    = 18,
   parameter int          SLOT_W       = 96,
   parameter logic [31:0] EMPTY_MARKER = 32'hDEADBEEF,
   parameter int          USER_W       = 16
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   timestamp_inserter_if.slave  s_axis,
   timestamp_inserter_if.master m_axis,
   input  logic                 i_enable,
   input  logic                 i_mark,
   input  logic                 i_sync_pulse,
   output logic [31:0]          o_nb_sync,
   output logic [63:0]          o_curr_tick,
   output logic                 o_injected,
   output logic                 o_no_slot
`ifdef TIMESTAMP_INSERTER_STATS_EN
   ,
   output logic [31:0]          o_inject_cnt,
   output logic [31:0]          o_noslot_cnt
`endif
);

   localparam int NUM_SLOTS = (DATA_W - 8*HDR_BYTES) / SLOT_W;
   localparam int SLOT_TOP  = DATA_W - 1 - 8*HDR_BYTES;

   logic [NUM_SLOTS-1:0] slot_free;
   logic [NUM_SLOTS-1:0] first_free;
   logic                 found;
   logic [DATA_W-1:0]    stamped;
   logic                 load;
   logic                 do_mark;
   logic                 sof;

   logic                 m_valid;
   logic [DATA_W-1:0]    m_data;
   logic [DATA_W/8-1:0]  m_keep;
   logic                 m_last;
   logic [USER_W-1:0]    m_user;

   // A slot is usable only if it carries the empty marker and all its bytes are valid.
   for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
      localparam int TOP = SLOT_TOP - k*SLOT_W;
      localparam int LO  = TOP - SLOT_W + 1;
      assign slot_free[k] = (s_axis.tdata[TOP -: 32] == EMPTY_MARKER) &&
                            (&s_axis.tkeep[LO/8 +: SLOT_W/8]);
   end

   // Isolate the lowest set bit: lowest-index free slot wins.
   assign first_free = slot_free & (~slot_free + NUM_SLOTS'(1));
   assign found      = |slot_free;

   always_comb begin
      stamped = s_axis.tdata;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         if (first_free[k]) begin
            stamped[SLOT_TOP - k*SLOT_W -: 32]              = o_nb_sync;
            stamped[SLOT_TOP - k*SLOT_W - SLOT_W + 1 +: 64] = o_curr_tick;
         end
      end
   end

   // Output register can take a new beat when empty or being drained this cycle.
   assign load           = !m_valid || m_axis.tready;
   assign s_axis.tready  = load;
   assign do_mark        = s_axis.tvalid && sof && i_enable && i_mark;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_valid     <= 1'b0;
         m_data      <= '0;
         m_keep      <= '0;
         m_last      <= 1'b0;
         m_user      <= '0;
         o_injected  <= 1'b0;
         o_no_slot   <= 1'b0;
         sof         <= 1'b1;
         o_nb_sync   <= '0;
         o_curr_tick <= '0;
      end else begin
         o_curr_tick <= o_curr_tick + 64'd1;
         if (i_sync_pulse) o_nb_sync <= o_nb_sync + 32'd1;
         // Pulses are tied to the output register contents, so they hold during a stall.
         if (load) begin
            m_valid    <= s_axis.tvalid;
            o_injected <= do_mark && found;
            o_no_slot  <= do_mark && !found;
            if (s_axis.tvalid) begin
               m_data <= (do_mark && found) ? stamped : s_axis.tdata;
               m_keep <= s_axis.tkeep;
               m_last <= s_axis.tlast;
               m_user <= s_axis.tuser;
               sof    <= s_axis.tlast;
            end
         end
      end
   end

   assign m_axis.tvalid = m_valid;
   assign m_axis.tdata  = m_data;
   assign m_axis.tkeep  = m_keep;
   assign m_axis.tlast  = m_last;
   assign m_axis.tuser  = m_user;

`ifdef TIMESTAMP_INSERTER_STATS_EN
   // Count events at the load, not cycles the pulse is held through a stall.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         o_inject_cnt <= '0;
         o_noslot_cnt <= '0;
      end else if (load && do_mark) begin
         if (found && o_inject_cnt != 32'hFFFF_FFFF)
            o_inject_cnt <= o_inject_cnt + 32'd1;
         if (!found && o_noslot_cnt != 32'hFFFF_FFFF)
            o_noslot_cnt <= o_noslot_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_timestamp_inserter.sv
module tb_timestamp_inserter;
   localparam int DW = 512;
   localparam int UW = 16;
   localparam int KW = DW/8;
   localparam int HB = 18;
   localparam int SW = 96;
   localparam int NS = (DW - 8*HB) / SW;
   localparam int S0 = DW - 1 - 8*HB;
   localparam int S1 = S0 - SW;
   localparam int S2 = S1 - SW;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   timestamp_inserter_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
   timestamp_inserter_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

   logic        i_enable, i_mark, i_sync_pulse;
   logic [31:0] o_nb_sync;
   logic [63:0] o_curr_tick;
   logic        o_injected, o_no_slot;
`ifdef TIMESTAMP_INSERTER_STATS_EN
   logic [31:0] o_inject_cnt, o_noslot_cnt;
`endif

   timestamp_inserter dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis(s_if.slave), .m_axis(m_if.master),
      .i_enable(i_enable), .i_mark(i_mark), .i_sync_pulse(i_sync_pulse),
      .o_nb_sync(o_nb_sync), .o_curr_tick(o_curr_tick),
      .o_injected(o_injected), .o_no_slot(o_no_slot)
`ifdef TIMESTAMP_INSERTER_STATS_EN
      , .o_inject_cnt(o_inject_cnt), .o_noslot_cnt(o_noslot_cnt)
`endif
   );

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
      logic [UW-1:0] u;
   } beat_t;

   beat_t       q[$];
   int          checks = 0;
   int          errors = 0;
   int          out_cnt = 0;
   logic [63:0] tick_m;
   logic [31:0] sync_m, inj_cnt_m, nos_cnt_m;
   logic        sof_m, inj_m, nos_m;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: walk slots in ascending order, stamp the first one that is free.
   function automatic logic [DW:0] ref_stamp(input logic [DW-1:0] data, input logic [KW-1:0] keep,
                                             input logic [63:0] tick, input logic [31:0] sync);
      int            lo;
      logic [SW-1:0] slot;
      logic [DW-1:0] mask;
      for (int k = 0; k < NS; k++) begin
         lo   = DW - 8*HB - (k+1)*SW;
         slot = SW'(data >> lo);
         if (slot[SW-1 -: 32] == 32'hDEADBEEF && ((keep >> (lo/8)) & KW'(12'hFFF)) == KW'(12'hFFF)) begin
            mask = DW'({SW{1'b1}}) << lo;
            return {1'b1, (data & ~mask) | (DW'({sync, tick}) << lo)};
         end
      end
      return {1'b0, data};
   endfunction

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [DW-1:0] with_markers(input logic [DW-1:0] d, input logic [31:0] m0,
                                                  input logic [31:0] m1, input logic [31:0] m2);
      logic [DW-1:0] r;
      r = d;
      r[S0 -: 32] = m0;
      r[S1 -: 32] = m1;
      r[S2 -: 32] = m2;
      return r;
   endfunction

   task automatic model_reset();
      q.delete();
      tick_m = '0; sync_m = '0; inj_cnt_m = '0; nos_cnt_m = '0;
      sof_m = 1'b1; inj_m = 1'b0; nos_m = 1'b0;
   endtask

   // One clock: check outputs at the negedge, advance the model, step past the posedge.
   task automatic cycle(output logic acc);
      logic  rdy, mk;
      logic [DW:0] r;
      beat_t b;
      @(negedge aclk);
      chk("m_tvalid", DW'(m_if.tvalid), DW'(q.size() != 0));
      if (q.size() != 0) begin
         chk("m_tdata", m_if.tdata, q[0].d);
         chk("m_tkeep", DW'(m_if.tkeep), DW'(q[0].k));
         chk("m_tlast", DW'(m_if.tlast), DW'(q[0].l));
         chk("m_tuser", DW'(m_if.tuser), DW'(q[0].u));
      end
      chk("s_tready", DW'(s_if.tready), DW'(q.size() == 0 || m_if.tready));
      chk("injected", DW'(o_injected), DW'(inj_m));
      chk("no_slot", DW'(o_no_slot), DW'(nos_m));
      chk("tick", DW'(o_curr_tick), DW'(tick_m));
      chk("nb_sync", DW'(o_nb_sync), DW'(sync_m));
`ifdef TIMESTAMP_INSERTER_STATS_EN
      chk("inject_cnt", DW'(o_inject_cnt), DW'(inj_cnt_m));
      chk("noslot_cnt", DW'(o_noslot_cnt), DW'(nos_cnt_m));
`endif
      rdy = (q.size() == 0) || m_if.tready;
      acc = rdy && s_if.tvalid;
      if (q.size() != 0 && m_if.tready) begin
         void'(q.pop_front());
         out_cnt++;
      end
      if (rdy) begin
         inj_m = 1'b0;
         nos_m = 1'b0;
         if (s_if.tvalid) begin
            mk  = sof_m && i_enable && i_mark;
            r   = ref_stamp(s_if.tdata, s_if.tkeep, tick_m, sync_m);
            b.d = (mk && r[DW]) ? r[DW-1:0] : s_if.tdata;
            b.k = s_if.tkeep;
            b.l = s_if.tlast;
            b.u = s_if.tuser;
            inj_m = mk && r[DW];
            nos_m = mk && !r[DW];
            if (inj_m && inj_cnt_m != 32'hFFFF_FFFF) inj_cnt_m++;
            if (nos_m && nos_cnt_m != 32'hFFFF_FFFF) nos_cnt_m++;
            sof_m = s_if.tlast;
            q.push_back(b);
         end
      end
      tick_m++;
      if (i_sync_pulse) sync_m++;
      @(posedge aclk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                        input logic l, input logic [UW-1:0] u, input logic mark);
      s_if.tvalid = v; s_if.tdata = d; s_if.tkeep = k;
      s_if.tlast  = l; s_if.tuser = u; i_mark = mark;
   endtask

   task automatic idle(input int n);
      logic acc;
      drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
      for (int i = 0; i < n; i++) cycle(acc);
   endtask

   // Present a beat until accepted; randomise ready/sync each cycle when rnd is set.
   task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                       input logic [UW-1:0] u, input logic mark, input bit rnd);
      logic acc;
      bit   done;
      done = 0;
      for (int t = 0; t < 100 && !done; t++) begin
         if (rnd) begin
            m_if.tready  = ($urandom_range(0, 3) != 0);
            i_sync_pulse = ($urandom_range(0, 4) == 0);
         end
         drive(1'b1, d, k, l, u, mark);
         cycle(acc);
         done = acc;
      end
      if (!done) chk("accept_timeout", DW'(0), DW'(1));
      i_sync_pulse = 1'b0;
      drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      logic          acc;
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic [31:0]   mk0, mk1, mk2;
      int            b, len, n0;
      bit            pat [7];

      i_enable = 1'b1; i_sync_pulse = 1'b0; m_if.tready = 1'b1;
      drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
      model_reset();
      @(posedge aclk); #1;
      chk("rst_m_tvalid", DW'(m_if.tvalid), DW'(0));
      chk("rst_tdata", m_if.tdata, '0);
      chk("rst_tick", DW'(o_curr_tick), DW'(0));
      chk("rst_sync", DW'(o_nb_sync), DW'(0));
      chk("rst_pulses", DW'({o_injected, o_no_slot}), DW'(0));
      aresetn = 1'b1;

      // Single beat, slot 0 free, tick=0x10, nb_sync=2.
      drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
      i_sync_pulse = 1'b1; cycle(acc); cycle(acc); i_sync_pulse = 1'b0;
      while (tick_m != 64'h10) cycle(acc);
      d = with_markers(rnd_data(), 32'hDEADBEEF, 32'h0, 32'h0);
      send(d, '1, 1'b1, 16'h00A1, 1'b1, 0);
      chk("t1_slot0", DW'(m_if.tdata[S0 -: SW]), DW'({32'h2, 64'h10}));
      chk("t1_injected", DW'(o_injected), DW'(1));
      idle(1);

      // Slot 0 occupied: stamp goes to slot 1.
      d = with_markers(rnd_data(), 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF);
      send(d, '1, 1'b1, 16'h00A2, 1'b1, 0);
      chk("t2_slot0", DW'(m_if.tdata[S0 -: 32]), DW'(32'h12345678));
      chk("t2_slot1_sync", DW'(m_if.tdata[S1 -: 32]), DW'(32'h2));
      idle(1);

      // Only candidate slot has a partial tkeep: no slot.
      d = with_markers(rnd_data(), 32'h11111111, 32'h22222222, 32'hDEADBEEF);
      k = '1;
      k[(S2 - SW + 1)/8 +: SW/8] = '0;
      send(d, k, 1'b1, 16'h00A3, 1'b1, 0);
      chk("t3_data", m_if.tdata, d);
      chk("t3_no_slot", DW'(o_no_slot), DW'(1));
`ifdef TIMESTAMP_INSERTER_STATS_EN
      chk("t3_noslot_cnt", DW'(o_noslot_cnt), DW'(1));
`endif
      idle(1);

      // 3-beat packet, mark on every beat, downstream ready 1,0,0,1,...
      pat = '{1, 0, 0, 1, 1, 1, 1};
      n0 = out_cnt;
      b = 0;
      for (int i = 0; i < 7; i++) begin
         m_if.tready = pat[i];
         if (b < 3) drive(1'b1, with_markers(rnd_data(), 32'hDEADBEEF, 32'hDEADBEEF, 32'h0),
                          '1, (b == 2), UW'(b), 1'b1);
         else       drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
         cycle(acc);
         if (acc) b++;
      end
      idle(2);
      chk("t4_accepted", DW'(b), DW'(3));
      chk("t4_delivered", DW'(out_cnt - n0), DW'(3));

      // Sync pulse coincident with inject at nb_sync=7.
      i_sync_pulse = 1'b1;
      while (sync_m != 32'd7) cycle(acc);
      i_sync_pulse = 1'b0;
      d = with_markers(rnd_data(), 32'hDEADBEEF, 32'h0, 32'h0);
      i_sync_pulse = 1'b1;
      drive(1'b1, d, '1, 1'b1, 16'h00A5, 1'b1);
      cycle(acc);
      i_sync_pulse = 1'b0;
      drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
      chk("t5_stamp_sync", DW'(m_if.tdata[S0 -: 32]), DW'(32'd7));
      chk("t5_nb_sync", DW'(o_nb_sync), DW'(32'd8));
      idle(1);

      // Randomised packets with backpressure, sync pulses and enable toggling.
      for (int p = 0; p < 40; p++) begin
         len = $urandom_range(1, 4);
         i_enable = ($urandom_range(0, 5) != 0);
         for (int j = 0; j < len; j++) begin
            mk0 = $urandom_range(0, 1) ? 32'hDEADBEEF : $urandom;
            mk1 = $urandom_range(0, 1) ? 32'hDEADBEEF : $urandom;
            mk2 = $urandom_range(0, 1) ? 32'hDEADBEEF : $urandom;
            k = '1;
            if ($urandom_range(0, 3) == 0) k = {$urandom, $urandom};
            send(with_markers(rnd_data(), mk0, mk1, mk2), k, (j == len - 1),
                 UW'($urandom), $urandom_range(0, 1), 1);
         end
      end
      i_enable = 1'b1;
      m_if.tready = 1'b1;
      idle(3);

      // Reset in the middle of a 4-beat packet.
      for (int j = 0; j < 2; j++)
         send(with_markers(rnd_data(), 32'hDEADBEEF, 32'h0, 32'h0), '1, 1'b0, UW'(j), 1'b1, 0);
      aresetn = 1'b0;
      #1;
      chk("t6_m_tvalid", DW'(m_if.tvalid), DW'(0));
      chk("t6_tick", DW'(o_curr_tick), DW'(0));
      chk("t6_sync", DW'(o_nb_sync), DW'(0));
      model_reset();
      @(posedge aclk); #1;
      aresetn = 1'b1;
      idle(2);
      d = with_markers(rnd_data(), 32'hDEADBEEF, 32'h0, 32'h0);
      send(d, '1, 1'b0, 16'h00A6, 1'b1, 0);
      chk("t6_injected", DW'(o_injected), DW'(1));
      chk("t6_slot0_tick", DW'(m_if.tdata[S0 - 32 -: 64]), DW'(64'd2));
      send(rnd_data(), '1, 1'b1, 16'h00A7, 1'b1, 0);
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
